// File: rtl/fpu_pkg.sv
// Shared binary32 constants and field packing used across the FPU blocks
// (itof, ftoi, fadd, fmul).
package fpu_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Assemble a binary32 word from its three fields.
  function automatic logic [31:0] fp_pack(input logic              sign,
                                          input logic [EXP_W-1:0]  exp,
                                          input logic [FRAC_W-1:0] frac);
    fp32_t f;
    f.sign = sign;
    f.exp  = exp;
    f.frac = frac;
    return f;
  endfunction

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter. For in==0 the count reads 0
// and zero is raised; callers key off zero in that case.
module lzc32 (
  input  logic [31:0] in,
  output logic [4:0]  cnt,
  output logic        zero
);

  // Scan LSB to MSB so the highest set bit determines the count.
  always_comb begin
    cnt = 5'd0;
    for (int i = 0; i < 32; i++) begin
      cnt = in[i] ? 5'(31 - i) : cnt;
    end
    zero = (in == 32'd0);
  end

endmodule

// File: rtl/itof.sv
// Two-stage int32 -> binary32 converter with valid/ready handshake.
// S1: sign/magnitude and leading-zero count. S2: normalise, round to
// nearest-even, pack. d and out_valid come straight from S2 registers.
module itof
  import fpu_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] s,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d
);

  // Exponent of a magnitude whose top set bit is bit 31 (lz == 0).
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_BIAS + 31);

  logic        v1_r;
  logic        v2_r;
  logic        sign1_r;
  logic        zero1_r;
  logic [31:0] mag1_r;
  logic [4:0]  lz1_r;
  logic [31:0] d_r;

  logic        adv1_s;
  logic        adv2_s;
  logic        sign_s;
  logic [31:0] mag_s;
  logic [4:0]  lz_s;
  logic        zero_s;

  logic [31:0]       norm_s;
  logic [FRAC_W-1:0] frac_s;
  logic              guard_s;
  logic              sticky_s;
  logic              inc_s;
  logic [24:0]       sum_s;
  logic              carry_s;
  logic [EXP_W-1:0]  exp_s;
  logic [FRAC_W-1:0] frac_rnd_s;
  logic [31:0]       result_s;

  // Pipeline advance: a stage moves when it is empty or its successor moves.
  always_comb begin
    adv2_s = !v2_r | out_ready;
    adv1_s = !v1_r | adv2_s;
  end

  assign in_ready  = adv1_s;
  assign out_valid = v2_r;
  assign d         = d_r;

  // S1 front end: sign extraction and two's-complement magnitude.
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    sign_s = SIGNED & s[31];
    mag_s  = sign_s ? (~s + 32'd1) : s;
  end

  lzc32 u_lzc (
    .in   (mag_s),
    .cnt  (lz_s),
    .zero (zero_s)
  );

  // S2 datapath: normalise, round to nearest-even, pack; zero forces +0.
  always_comb begin
    norm_s     = mag1_r << lz1_r;
    frac_s     = norm_s[30:8];
    guard_s    = norm_s[7];
    sticky_s   = |norm_s[6:0];
    inc_s      = guard_s & (sticky_s | frac_s[0]);
    sum_s      = {1'b0, 1'b1, frac_s} + {24'd0, inc_s};
    carry_s    = sum_s[24];
    exp_s      = EXP_TOP - {3'd0, lz1_r} + {7'd0, carry_s};
    frac_rnd_s = carry_s ? {FRAC_W{1'b0}} : sum_s[22:0];
    if (zero1_r) begin
      result_s = 32'd0;
    end else begin
      result_s = fp_pack(sign1_r, exp_s, frac_rnd_s);
    end
  end

  // S1 register: capture operand analysis whenever the stage can advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r    <= 1'b0;
      sign1_r <= 1'b0;
      zero1_r <= 1'b0;
      mag1_r  <= 32'd0;
      lz1_r   <= 5'd0;
    end else if (adv1_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        sign1_r <= sign_s;
        zero1_r <= zero_s;
        mag1_r  <= mag_s;
        lz1_r   <= lz_s;
      end
    end
  end

  // S2 register: holds the result stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r <= 1'b0;
      d_r  <= 32'd0;
    end else if (adv2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        d_r <= result_s;
      end
    end
  end

endmodule
